// File: rtl/uart_image_ctrl_if.sv
// rtl/uart_image_ctrl_if.sv - external synchronous RAM bus between the image controller and the RAM
interface uart_image_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    modport master (output ram_addr, output ram_wdata, output ram_we, input ram_rdata);
    modport slave  (input ram_addr, input ram_wdata, input ram_we, output ram_rdata);
endinterface

// File: rtl/uart_image_ctrl.sv
// rtl/uart_image_ctrl.sv - UART image loader/dumper with RAM address mux
// Optional even-parity 8E1 framing when UART_PARITY_EN is defined (default 8N1).
module uart_image_ctrl #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 18,
    parameter int IMG_BYTES    = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_serial,
    output logic              tx_serial,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] ext_addr,
    output logic              load_done,
    output logic              dump_done,
    output logic              busy,
    output logic              tx_active,
    output logic              frame_err,
    uart_image_ctrl_if.master ram
);
`ifdef UART_PARITY_EN
    localparam int RX_BITS = 9;
    localparam int TX_BITS = 11;
`else
    localparam int RX_BITS = 8;
    localparam int TX_BITS = 10;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]        RXI_LAST  = 4'(RX_BITS - 1);
    localparam logic [3:0]        TXI_LAST  = 4'(TX_BITS - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(IMG_BYTES - 1);

    localparam logic [1:0] S_LOAD = 2'd0, S_HOLD = 2'd1, S_DUMP = 2'd2;
    localparam logic [1:0] D_RD = 2'd0, D_WAIT = 2'd1, D_SEND = 2'd2, D_DRAIN = 2'd3;
    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

    logic [1:0]         state, sub, rx_state;
    logic [ADDR_W-1:0]  ptr, base_q;
    logic               we_q, load_done_q, dump_done_q, frame_err_q;
    logic [7:0]         wdata_q;
    logic               rx_s1, rx_s2, rx_prev, rx_valid, rx_err, byte_ok;
    logic [CW-1:0]      rx_cnt, tx_cnt;
    logic [3:0]         rx_idx, tx_idx;
    logic [RX_BITS-1:0] rx_shift;
    logic [TX_BITS-1:0] tx_shift, tx_frame;
    logic               tx_active_q, tx_start, tx_last;

`ifdef UART_PARITY_EN
    assign byte_ok  = rx_s2 && (rx_shift[8] == ^rx_shift[7:0]);
    assign tx_frame = {1'b1, ^ram.ram_rdata, ram.ram_rdata, 1'b0};
`else
    assign byte_ok  = rx_s2;
    assign tx_frame = {1'b1, ram.ram_rdata, 1'b0};
`endif

    // Receiver runs in every state; only LOAD consumes its bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_state <= RX_IDLE; rx_cnt <= '0; rx_idx <= '0; rx_shift <= '0;
            rx_valid <= 1'b0; rx_err <= 1'b0;
        end else begin
            rx_s1    <= rx_serial;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_DATA: if (rx_cnt == CNT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[RX_BITS-1:1]};
                    if (rx_idx == RXI_LAST) rx_state <= RX_STOP;
                    else                    rx_idx   <= rx_idx + 1'b1;
                end else rx_cnt <= rx_cnt + 1'b1;
                default: if (rx_cnt == CNT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_IDLE;
                    rx_valid <= byte_ok;
                    rx_err   <= !byte_ok;
                end else rx_cnt <= rx_cnt + 1'b1;
            endcase
        end
    end

    assign tx_start  = (state == S_DUMP) && (sub == D_SEND);
    assign tx_last   = tx_active_q && (tx_cnt == CNT_LAST) && (tx_idx == TXI_LAST);
    assign tx_serial = tx_active_q ? tx_shift[0] : 1'b1;
    assign tx_active = tx_active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active_q <= 1'b0; tx_shift <= '1; tx_cnt <= '0; tx_idx <= '0;
        end else if (tx_start) begin
            tx_active_q <= 1'b1;
            tx_shift    <= tx_frame;
            tx_cnt      <= '0;
            tx_idx      <= '0;
        end else if (tx_active_q) begin
            if (tx_cnt == CNT_LAST) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[TX_BITS-1:1]};
                if (tx_idx == TXI_LAST) tx_active_q <= 1'b0;
                else                    tx_idx      <= tx_idx + 1'b1;
            end else tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // ptr advances as the write strobe retires, so ram_addr still holds the write address during ram_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD; sub <= D_RD; ptr <= '0; base_q <= '0;
            we_q <= 1'b0; wdata_q <= '0;
            load_done_q <= 1'b0; dump_done_q <= 1'b0; frame_err_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (rx_err) frame_err_q <= 1'b1;
            case (state)
                S_LOAD: if (we_q) begin
                    if (ptr == PTR_LAST) begin
                        ptr         <= '0;
                        load_done_q <= 1'b1;
                        state       <= S_HOLD;
                    end else ptr <= ptr + 1'b1;
                end else if (rx_valid) begin
                    we_q    <= 1'b1;
                    wdata_q <= rx_shift[7:0];
                end
                S_HOLD: if (start_load) begin
                    state       <= S_LOAD;
                    load_done_q <= 1'b0;
                    dump_done_q <= 1'b0;
                    frame_err_q <= 1'b0;
                end else if (start_dump) begin
                    state       <= S_DUMP;
                    sub         <= D_RD;
                    base_q      <= dump_base;
                    ptr         <= '0;
                    dump_done_q <= 1'b0;
                end
                default: case (sub)
                    D_RD:   sub <= D_WAIT;
                    D_WAIT: sub <= D_SEND;
                    D_SEND: sub <= D_DRAIN;
                    default: if (tx_last) begin
                        sub <= D_RD;
                        if (ptr == PTR_LAST) begin
                            ptr         <= '0;
                            dump_done_q <= 1'b1;
                            state       <= S_HOLD;
                        end else ptr <= ptr + 1'b1;
                    end
                endcase
            endcase
        end
    end

    always_comb begin
        ram.ram_addr = ptr;
        if (state == S_HOLD)      ram.ram_addr = ext_addr;
        else if (state == S_DUMP) ram.ram_addr = base_q + ptr;
    end

    assign ram.ram_we    = we_q;
    assign ram.ram_wdata = wdata_q;
    assign load_done     = load_done_q;
    assign dump_done     = dump_done_q;
    assign frame_err     = frame_err_q;
    assign busy          = ((state == S_LOAD) && (ptr != '0)) || (state == S_DUMP);
endmodule
